// File: rtl/alu_issue_unit_if.sv
// Request/result bundle for alu_issue_unit. The master issues operations and
// consumes results; the slave is the issue unit itself.
interface alu_issue_unit_if #(
  parameter int WIDTH = 32
);
  // Both channels use plain valid/ready: a transfer happens on a rising edge
  // where valid && ready. Once raised, valid and its payload are held until
  // that transfer, and ready never depends combinationally on valid.
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output in_valid, opcode, op_a, op_b, res_ready,
    input  in_ready, res_valid, result, zero, carry, illegal
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, res_ready,
    output in_ready, res_valid, result, zero, carry, illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue/result front end for the integer ALU: one op per handshake, iterative
// shifts by default, single-cycle barrel shifts when ALU_SHIFT_FAST_EN is defined.
module alu_issue_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_unit_if.slave    bus,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    logic [1:0]       state;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             illegal_q;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] c_res;
    logic             c_carry;
    logic             c_illegal;
    logic             c_iter;
    logic [WIDTH-1:0] step_res;
    logic             step_carry;
`ifdef ALU_SHIFT_FAST_EN
    logic [WIDTH:0]   wide;
`endif

    assign shamt = bus.op_b[SHW-1:0];

    // Result for an op that completes on the accept edge.
    always_comb begin
        sum       = '0;
        c_res     = '0;
        c_carry   = 1'b0;
        c_illegal = 1'b0;
        c_iter    = 1'b0;
`ifdef ALU_SHIFT_FAST_EN
        wide      = '0;
`endif
        case (bus.opcode)
            OP_ADD: begin
                sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
            end
            OP_SUB: begin
                sum     = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + {{WIDTH{1'b0}}, 1'b1};
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
            end
            OP_AND: c_res = bus.op_a & bus.op_b;
            OP_OR:  c_res = bus.op_a | bus.op_b;
            OP_XOR: c_res = bus.op_a ^ bus.op_b;
            OP_NOT: c_res = ~bus.op_a;
            OP_SLL, OP_SRL, OP_SRA: begin
`ifdef ALU_SHIFT_FAST_EN
                // One spare bit beside the operand catches the last bit shifted out.
                if (bus.opcode == OP_SLL) begin
                    wide    = {1'b0, bus.op_a} << shamt;
                    c_res   = wide[WIDTH-1:0];
                    c_carry = wide[WIDTH];
                end else begin
                    if (bus.opcode == OP_SRA)
                        wide = $signed({bus.op_a, 1'b0}) >>> shamt;
                    else
                        wide = {bus.op_a, 1'b0} >> shamt;
                    c_res   = wide[WIDTH:1];
                    c_carry = wide[0];
                end
`else
                if (shamt == '0)
                    c_res = bus.op_a;
                else
                    c_iter = 1'b1;
`endif
            end
            default: c_illegal = 1'b1;
        endcase
    end

    // One-bit step of the iterative shifter, applied to the working value.
    always_comb begin
        step_res   = result_q;
        step_carry = 1'b0;
        case (op_q)
            OP_SLL: begin
                step_res   = {result_q[WIDTH-2:0], 1'b0};
                step_carry = result_q[WIDTH-1];
            end
            OP_SRL: begin
                step_res   = {1'b0, result_q[WIDTH-1:1]};
                step_carry = result_q[0];
            end
            OP_SRA: begin
                step_res   = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                step_carry = result_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        illegal_q <= c_illegal;
                        carry_q   <= c_carry;
                        op_q      <= bus.opcode;
                        if (c_iter) begin
                            // result_q doubles as the shift register while in SHIFT.
                            result_q <= bus.op_a;
                            zero_q   <= 1'b0;
                            cnt_q    <= shamt;
                            state    <= SHIFT;
                        end else begin
                            result_q <= c_res;
                            zero_q   <= (c_res == '0);
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= step_res;
                    carry_q  <= step_carry;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        zero_q <= (step_res == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed plus random bench for alu_issue_unit with a result scoreboard.
module tb_alu_issue_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int checks;
  int errors;
  logic [W+2:0] exp_q[$];  // {illegal, carry, zero, result}

  alu_issue_unit_if #(.WIDTH(W)) bus ();

  alu_issue_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] pack(input logic ill, input logic c, input logic [W-1:0] r);
    return {ill, c, (r == '0), r};
  endfunction

  // Reference model from the arithmetic/shift definitions.
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] s;
    logic [W-1:0] r;
    logic c;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[W-1:0]; c = s[W]; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6, 4'd7, 4'd8: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) begin
          if (op == 4'd6) begin c = r[W-1]; r = r << 1; end
          else begin c = r[0]; r = {(op == 4'd8) ? r[W-1] : 1'b0, r[W-1:1]}; end
        end
      end
      default: return pack(1'b1, 1'b0, '0);
    endcase
    return pack(1'b0, c, r);
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_SHIFT_FAST_EN
    return 1;
`else
    if (op >= 4'd6 && op <= 4'd8) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Scoreboard: compare the front entry against the DUT outputs.
  task automatic collect(input string tag);
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_result"}, bus.result, e[W-1:0]);
    chk({tag, "_zero"}, W'(bus.zero), W'(e[W]));
    chk({tag, "_carry"}, W'(bus.carry), W'(e[W+1]));
    chk({tag, "_illegal"}, W'(bus.illegal), W'(e[W+2]));
  endtask

  // Driver: issue one op, time its latency, check it, let it drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W+2:0] e, input int lat);
    int n;
    @(negedge clk);
    chk({tag, "_in_ready"}, W'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 200);
    chk({tag, "_latency"}, W'(n), W'(lat));
    collect(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] a, b, held;
    logic [3:0] op;
    int seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), 1);
    chk("rst_res_valid", W'(bus.res_valid), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", W'(bus.zero), 0);
    chk("rst_carry", W'(bus.carry), 0);
    chk("rst_illegal", W'(bus.illegal), 0);
    chk("rst_state", W'(dbg_state), 0);

    run_op("xor", 4'd4, 32'hF0F0_1234, 32'hFFFF_1234, pack(0, 0, 32'h0F0F_0000), 1);
    run_op("xor_self", 4'd4, 32'hF0F0_1234, 32'hF0F0_1234, pack(0, 0, 32'h0), 1);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, pack(0, 1, 32'h0), 1);
    run_op("sub_borrow", 4'd1, 32'd5, 32'd7, pack(0, 0, 32'hFFFF_FFFE), 1);
    run_op("sra4", 4'd8, 32'h8000_0001, 32'd4, pack(0, 0, 32'hF800_0000), exp_lat(4'd8, 32'd4));
    run_op("sll1", 4'd6, 32'h8000_0000, 32'd1, pack(0, 1, 32'h0), exp_lat(4'd6, 32'd1));
    run_op("srl0", 4'd7, 32'hDEAD_BEEF, 32'hFFFF_FFE0, pack(0, 0, 32'hDEAD_BEEF), 1);
    run_op("not", 4'd5, 32'h1234_5678, 32'hFFFF_FFFF, pack(0, 0, 32'hEDCB_A987), 1);
    run_op("illegal12", 4'd12, 32'h1, 32'h2, pack(1, 0, 32'h0), 1);
    run_op("or_after_ill", 4'd3, 32'hA000_0000, 32'h0000_000A, pack(0, 0, 32'hA000_000A), 1);

    // Backpressure: result held while a second request waits outside.
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd2;
    bus.op_a     = 32'hFF00_FF00;
    bus.op_b     = 32'h0FF0_0FF0;
    exp_q.push_back(pack(0, 0, 32'h0F00_0F00));
    @(posedge clk);
    #1 bus.opcode = 4'd0;
    bus.op_a = 32'h1111_1111;
    bus.op_b = 32'h2222_2222;
    @(negedge clk);
    chk("bp_valid", W'(bus.res_valid), 1);
    collect("bp_first");
    exp_q.push_back(pack(0, 0, 32'h0F00_0F00));
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", W'(bus.res_valid), 1);
      chk("bp_hold_in_ready", W'(bus.in_ready), 0);
      chk("bp_hold_result", bus.result, 32'h0F00_0F00);
    end
    collect("bp_held");
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", W'(bus.in_ready), 1);
    chk("bp_release_valid", W'(bus.res_valid), 0);
    chk("bp_release_result", bus.result, 32'h0F00_0F00);

    // Reset in the middle of a long shift: no result may appear.
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd6;
    bus.op_a     = 32'h0000_ABCD;
    bus.op_b     = 32'd20;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", W'(bus.in_ready), 1);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_carry", W'(bus.carry), 0);
    chk("mid_rst_zero", W'(bus.zero), 0);
    chk("mid_rst_state", W'(dbg_state), 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("mid_rst_no_result", W'(seen), 0);

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      run_op("rand", op, a, b, model(op, a, b), exp_lat(op, b));
    end

    chk("sb_drained", W'(exp_q.size()), 0);
    held = bus.result;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
